// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - opcodes, state enum, datapath select encodings and control bundle for mc_control_unit
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_R_WB,
        S_BRANCH,
        S_JUMP,
        S_ADDI_EX,
        S_ADDI_WB,
        S_TRAP
    } state_t;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       ir_wr;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_wr;
        logic       reg_dst;
    } ctrl_t;

    // States whose exit back to FETCH marks a completed instruction.
    function automatic logic is_retire_state(input state_t s);
        return (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_R_WB) ||
               (s == S_BRANCH) || (s == S_JUMP)   || (s == S_ADDI_WB);
    endfunction

endpackage

// File: rtl/mc_op_decode.sv
// rtl/mc_op_decode.sv - classifies the instruction opcode into the supported instruction groups
module mc_op_decode
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] opcode,
    output logic            is_r,
    output logic            is_lw,
    output logic            is_sw,
    output logic            is_br,
    output logic            is_bne,
    output logic            is_j,
    output logic            is_addi,
    output logic            is_bad
);

    localparam logic [OP_W-1:0] C_RTYPE = OP_W'(OP_RTYPE);
    localparam logic [OP_W-1:0] C_LW    = OP_W'(OP_LW);
    localparam logic [OP_W-1:0] C_SW    = OP_W'(OP_SW);
    localparam logic [OP_W-1:0] C_BEQ   = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] C_BNE   = OP_W'(OP_BNE);
    localparam logic [OP_W-1:0] C_J     = OP_W'(OP_J);
    localparam logic [OP_W-1:0] C_ADDI  = OP_W'(OP_ADDI);

    assign is_r    = (opcode == C_RTYPE);
    assign is_lw   = (opcode == C_LW);
    assign is_sw   = (opcode == C_SW);
    assign is_bne  = (opcode == C_BNE);
    assign is_br   = (opcode == C_BEQ) || is_bne;
    assign is_j    = (opcode == C_J);
    assign is_addi = (opcode == C_ADDI);
    assign is_bad  = !(is_r || is_lw || is_sw || is_br || is_j || is_addi);

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle processor control FSM with retire counter and sticky illegal-opcode flag
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int CNT_W    = 16,
    parameter int MEM_WAIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic             pc_wr_cond,
    output logic             branch_ne,
    output logic             i_or_d,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             mem_to_reg,
    output logic             ir_wr,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_wr,
    output logic             reg_dst,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state;
    state_t           next_state;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;
    logic             ready;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic is_r, is_lw, is_sw, is_br, is_bne, is_j, is_addi, is_bad;

    assign ready = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

    mc_op_decode #(.OP_W(OP_W)) u_op_decode (
        .opcode  (opcode),
        .is_r    (is_r),
        .is_lw   (is_lw),
        .is_sw   (is_sw),
        .is_br   (is_br),
        .is_bne  (is_bne),
        .is_j    (is_j),
        .is_addi (is_addi),
        .is_bad  (is_bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            if ((next_state == S_FETCH) && is_retire_state(state)) begin
                retired_q <= retired_q + 1'b1;
            end
            if (next_state == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ctrl       = '0;
        next_state = state;
        case (state)
            S_FETCH: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                // Only these two strobes may depend on the memory handshake.
                ctrl.ir_wr     = ready;
                ctrl.pc_wr     = ready;
                if (ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_OP_ADD;
                if (is_r) begin
                    next_state = S_EXEC_R;
                end else if (is_lw || is_sw) begin
                    next_state = S_MEM_ADDR;
                end else if (is_br) begin
                    next_state = S_BRANCH;
                end else if (is_j) begin
                    next_state = S_JUMP;
                end else if (is_addi) begin
                    next_state = S_ADDI_EX;
                end else if (is_bad) begin
                    next_state = S_TRAP;
                end
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
                if (is_lw) begin
                    next_state = S_MEM_RD;
                end else if (is_sw) begin
                    next_state = S_MEM_WR;
                end else begin
                    next_state = S_TRAP;
                end
            end
            S_MEM_RD: begin
                ctrl.mem_rd = 1'b1;
                ctrl.i_or_d = 1'b1;
                if (ready) begin
                    next_state = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                next_state      = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_wr = 1'b1;
                ctrl.i_or_d = 1'b1;
                if (ready) begin
                    next_state = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_OP_FUNCT;
                next_state     = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.reg_dst = 1'b1;
                next_state   = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_B;
                ctrl.alu_op     = ALU_OP_SUB;
                ctrl.pc_wr_cond = 1'b1;
                ctrl.pc_src     = PC_SRC_ALUOUT;
                ctrl.branch_ne  = is_bne;
                next_state      = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_wr  = 1'b1;
                ctrl.pc_src = PC_SRC_JUMP;
                next_state  = S_FETCH;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
                next_state     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl.reg_wr = 1'b1;
                next_state  = S_FETCH;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Reset forces every strobe low at once, even though state already reads FETCH.
    assign ctrl_out = rst ? '0 : ctrl;

    assign pc_wr      = ctrl_out.pc_wr;
    assign pc_wr_cond = ctrl_out.pc_wr_cond;
    assign branch_ne  = ctrl_out.branch_ne;
    assign i_or_d     = ctrl_out.i_or_d;
    assign mem_rd     = ctrl_out.mem_rd;
    assign mem_wr     = ctrl_out.mem_wr;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign ir_wr      = ctrl_out.ir_wr;
    assign pc_src     = ctrl_out.pc_src;
    assign alu_op     = ctrl_out.alu_op;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign reg_wr     = ctrl_out.reg_wr;
    assign reg_dst    = ctrl_out.reg_dst;
    assign illegal    = illegal_q;
    assign retired    = retired_q;

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameters SHALL be: OP_W, default 6, opcode width; CNT_W, default 16, retire-counter width; MEM_WAIT, default 1, 1 = honour mem_ready, 0 = treat mem_ready as constant 1.
REQ-002 Ports SHALL be exactly the list in REQ-003 to REQ-022, in the form name, direction, width, meaning.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 opcode  in  OP_W  instruction[31:26], taken from the instruction register.
REQ-006 mem_ready  in  1  memory completes the current access this cycle.
REQ-007 pc_wr  out  1  unconditional PC write.
REQ-008 pc_wr_cond  out  1  conditional PC write (branch).
REQ-009 branch_ne  out  1  datapath uses the inverted zero flag for the branch condition.
REQ-010 i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 mem_rd  out  1  memory read strobe.
REQ-012 mem_wr  out  1  memory write strobe.
REQ-013 mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
REQ-014 ir_wr  out  1  instruction-register load.
REQ-015 pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-016 alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct.
REQ-017 alu_src_a  out  1  ALU A input: 0 = PC, 1 = A register.
REQ-018 alu_src_b  out  2  ALU B input: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-019 reg_wr  out  1  register-file write.
REQ-020 reg_dst  out  1  destination register: 0 = rt, 1 = rd.
REQ-021 illegal  out  1  sticky flag: an unsupported opcode was decoded.
REQ-022 retired  out  CNT_W  count of completed instructions.

Function
REQ-023 The block SHALL be a Moore FSM; exception: ir_wr and pc_wr in FETCH are ANDed with the effective mem_ready.
REQ-024 States SHALL be: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, TRAP.
REQ-025 FETCH: mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; stay while mem_ready=0; otherwise go to DECODE.
REQ-026 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode:
- 000000 -> EXEC_R
- 100011 or 101011 -> MEM_ADDR
- 000100 or 000101 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDI_EX
- any other opcode -> TRAP
REQ-027 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM_RD for lw, MEM_WR for sw.
REQ-028 MEM_RD: mem_rd=1, i_or_d=1; hold until mem_ready, then go to MEM_WB.
REQ-029 MEM_WB: reg_wr=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-030 MEM_WR: mem_wr=1, i_or_d=1; hold until mem_ready, then FETCH.
REQ-031 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB.
REQ-032 R_WB: reg_wr=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-033 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_wr_cond=1, pc_src=01, branch_ne = (opcode==000101); then FETCH.
REQ-034 JUMP: pc_wr=1, pc_src=10; then FETCH.
REQ-035 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDI_WB.
REQ-036 ADDI_WB: reg_wr=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-037 TRAP: all strobes 0, illegal=1; remain in TRAP until reset.
REQ-038 Any output not listed for a state SHALL be 0 in that state.
REQ-039 retired SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or ADDI_WB, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-040 Instruction cycle counts with zero wait states SHALL be: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3; each cycle mem_ready is held low adds one cycle.
REQ-041 With MEM_WAIT=0, the mem_ready input SHALL have no effect on behaviour.

Reset
REQ-042 While rst=1: state=FETCH, retired=0, illegal=0, and all outputs 0, including mem_rd.
REQ-043 rst asserted in any state, including mid-stall or TRAP, SHALL abort the current instruction with no partial retire count.
REQ-044 After rst is released, fetching SHALL resume on the first rising clk edge.

Structure
REQ-045 Package mc_pkg SHALL hold the opcode constants, the state enum, and the pc_src, alu_op and alu_src_b encodings.
REQ-046 Opcode classification SHALL be one sub-module, mc_op_decode: opcode in; is_r, is_lw, is_sw, is_br, is_bne, is_j, is_addi, is_bad out.

Verification
REQ-047 The bench SHALL cover these directed scenarios:
- lw (100011) with mem_ready=1 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_wr=1 and mem_to_reg=1 in cycle 5; retired 0 -> 1.
- sw with mem_ready low for 3 cycles in MEM_WR -> mem_wr=1 for 4 cycles; instruction completes in 7 cycles; reg_wr never asserted.
- bne (000101) -> BRANCH with pc_wr_cond=1, branch_ne=1, pc_src=01; beq -> branch_ne=0.
- Opcode 111111 -> TRAP, illegal=1 held for 10 cycles; rst pulse -> FETCH, illegal=0.
- CNT_W=4, 16 j instructions -> retired wraps from 15 to 0; MEM_WAIT=0 with mem_ready=0 -> fetch is not stalled.
- rst asserted mid-stall in MEM_RD -> all outputs 0 immediately (asynchronous); retired not incremented.
